imm_encoder: RTL and testbench

- Inverse of the immediate expander: takes a 32-bit constant plus an immediate class and produces the 24-bit instruction immediate field that the expander turns back into the same 32-bit value.
- Sits in the assembler/loader path, and in the test infrastructure ahead of instruction memory.
- Data-processing immediates need a sequential search over the 16 rotations. Memory and branch classes are single-cycle range checks.
- Start/done handshake; one encode at a time.

---
 rtl/imm_encoder.sv | 147 ++++++++++++++
 tb/tb_imm_encoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 32-bit constant into the 24-bit immediate field
// for the data-processing, memory or branch class. Define IMM_FAST_SEARCH_EN
// to test two rotations per SEARCH cycle.
module imm_encoder #(
    parameter int ROT_STEPS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    input  logic [1:0]  imm_src,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [23:0] immediate
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [3:0] ROT_LAST = 4'(ROT_STEPS - 1);

    state_e      state_q, state_d;
    logic [3:0]  rot_q, rot_d;
    logic [31:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic [23:0] imm_q, imm_d;

    logic        accept;
    logic [31:0] t0;
    logic        hit0;
    logic        last;
    logic [3:0]  rot_step;
    logic        mem_ok;
    logic        br_ok;

    function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] sh);
        logic [63:0] w;
        w = {v, v} << sh;
        return w[63:32];
    endfunction

    assign accept = start && (state_q != SEARCH);
    assign mem_ok = (value[31:12] == 20'd0);
    assign br_ok  = (value[31:24] == {8{value[23]}});

    // Match when the rotated value fits in imm8; the expander rotates it back right.
    assign t0   = rotl(value_q, {rot_q, 1'b0});
    assign hit0 = (t0[31:8] == 24'd0);

`ifdef IMM_FAST_SEARCH_EN
    logic [3:0]  rot1;
    logic [31:0] t1;
    logic        hit1;

    // rot_q is always even here, so the odd partner is rot_q with bit 0 set.
    assign rot1     = {rot_q[3:1], 1'b1};
    assign t1       = rotl(value_q, {rot1, 1'b0});
    assign hit1     = (t1[31:8] == 24'd0);
    assign last     = (rot1 == ROT_LAST);
    assign rot_step = 4'd2;
`else
    assign last     = (rot_q == ROT_LAST);
    assign rot_step = 4'd1;
`endif

    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        value_d = value_q;
        valid_d = valid_q;
        imm_d   = imm_q;
        case (state_q)
            SEARCH: begin
                if (hit0) begin
                    valid_d = 1'b1;
                    imm_d   = {12'd0, rot_q, t0[7:0]};
                    state_d = DONE;
`ifdef IMM_FAST_SEARCH_EN
                end else if (hit1) begin
                    valid_d = 1'b1;
                    imm_d   = {12'd0, rot1, t1[7:0]};
                    state_d = DONE;
`endif
                end else if (last) begin
                    valid_d = 1'b0;
                    imm_d   = 24'd0;
                    state_d = DONE;
                end else begin
                    rot_d = rot_q + rot_step;
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    case (imm_src)
                        2'd0: begin
                            state_d = SEARCH;
                            rot_d   = 4'd0;
                            value_d = value;
                        end
                        2'd1: begin
                            state_d = DONE;
                            valid_d = mem_ok;
                            imm_d   = mem_ok ? {12'd0, value[11:0]} : 24'd0;
                        end
                        2'd2: begin
                            state_d = DONE;
                            valid_d = br_ok;
                            imm_d   = br_ok ? value[23:0] : 24'd0;
                        end
                        default: begin
                            state_d = DONE;
                            valid_d = 1'b0;
                            imm_d   = 24'd0;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rot_q   <= 4'd0;
            value_q <= 32'd0;
            valid_q <= 1'b0;
            imm_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            value_q <= value_d;
            valid_q <= valid_d;
            imm_q   <= imm_d;
        end
    end

    assign busy      = (state_q == SEARCH);
    assign done      = (state_q == DONE);
    assign valid     = valid_q;
    assign immediate = imm_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed corner cases plus random encodes
// checked against a plain-arithmetic reference of the encoding rules.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic [1:0]  imm_src;
    logic        busy, done, valid;
    logic [23:0] immediate;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v;
        logic [23:0] imm;
        int          due;
    } exp_t;

    exp_t q[$];

    imm_encoder dut (
        .clk(clk), .reset(reset), .start(start), .value(value), .imm_src(imm_src),
        .busy(busy), .done(done), .valid(valid), .immediate(immediate)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rot_left(input logic [31:0] v, input int n);
        bit [63:0] w;
        w = {32'd0, v} << n;
        return w[31:0] | w[63:32];
    endfunction

    // Reference: lowest rotation r such that rotating left by 2r leaves a value below 256.
    function automatic exp_t model(input logic [31:0] v, input logic [1:0] src, input int acc);
        exp_t e;
        bit found;
        logic [31:0] t;
        e.v = 1'b0; e.imm = 24'd0; e.due = acc + 1;
        case (src)
            2'd0: begin
`ifdef IMM_FAST_SEARCH_EN
                e.due = acc + 9;
`else
                e.due = acc + 17;
`endif
                found = 0;
                for (int r = 0; r < 16; r++) begin
                    t = rot_left(v, 2 * r);
                    if (!found && t < 32'd256) begin
                        found = 1;
                        e.v   = 1'b1;
                        e.imm = 24'(r * 256 + int'(t));
`ifdef IMM_FAST_SEARCH_EN
                        e.due = acc + r / 2 + 2;
`else
                        e.due = acc + r + 2;
`endif
                    end
                end
            end
            2'd1: if (v < 32'd4096) begin e.v = 1'b1; e.imm = v[23:0]; end
            2'd2: if ($signed(v) >= -32'sd8388608 && $signed(v) <= 32'sd8388607) begin
                e.v = 1'b1; e.imm = v[23:0];
            end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_done: got done=1 expected no pending encode (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("valid", 32'(valid), 32'(e.v));
                chk("immediate", 32'(immediate), 32'(e.imm));
                chk("done_cycle", cyc, e.due);
            end
        end
    end

    task automatic issue(input logic [31:0] v, input logic [1:0] s);
        int n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        if (busy) begin
            checks++; errors++;
            $display("FAIL busy_timeout: got busy=1 expected 0 within 100 cycles");
        end
        start = 1'b1; value = v; imm_src = s;
        q.push_back(model(v, s, cyc));
        @(negedge clk);
        start = 1'b0; value = $urandom; imm_src = 2'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; value = 32'd0; imm_src = 2'd0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_imm", 32'(immediate), 0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        issue(32'h000000AB, 2'd0);
        issue(32'hFF000000, 2'd0);
        issue(32'hF000000F, 2'd0);
        issue(32'h000003FC, 2'd0);
        issue(32'h00000000, 2'd0);
        issue(32'h00000FFF, 2'd1);
        issue(32'h00001000, 2'd1);
        issue(32'hFF800000, 2'd2);
        issue(32'h00800000, 2'd2);
        issue(32'h12345678, 2'd3);
        issue(32'h007FFFFF, 2'd2);
        drain();

        // Starts while busy must be dropped without producing a done.
        issue(32'h00000101, 2'd0);
        @(negedge clk);
        begin
`ifdef IMM_FAST_SEARCH_EN
            int last_c = 7;
`else
            int last_c = 10;
`endif
            for (int c = 3; c <= last_c; c++) begin
                @(negedge clk);
                start = 1'b1; value = 32'h000000AB; imm_src = 2'd1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        drain();

        for (int i = 0; i < 200; i++) begin
            logic [31:0] v;
            logic [7:0]  b;
            int          r;
            b = 8'($urandom);
            r = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = rot_left({24'd0, b}, (32 - 2 * r) % 32);
                2: v = 32'($urandom_range(0, 8191));
                default: v = {{9{b[0]}}, 23'($urandom)};
            endcase
            issue(v, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        // Asynchronous reset mid-search leaves no result behind.
        issue(32'h00000FFF, 2'd1);
        drain();
        issue(32'h00000101, 2'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        q.delete();
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_imm", 32'(immediate), 0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        issue(32'h000000AB, 2'd0);
        issue(32'hFF000000, 2'd0);
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
